// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_pkg
// Description : Shared accelerator configuration types. Holds the DDR word
//               and address types plus the DDR responder state encoding and
//               default sizing/latency values.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

  typedef logic [31:0] ddr_address_t;
  typedef logic [31:0] ddr_data_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_DONE       = 2'd3
  } ddr_resp_state_t;

  localparam int DdrDepth        = 4096;
  localparam int DdrReadLatency  = 4;
  localparam int DdrWriteLatency = 2;

endpackage : config_pkg
`default_nettype wire

// File: rtl/ddr_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_responder_if
// Description : Requester <-> memory DDR request interface.
//               master : compute-unit requester (drives address/en/w_data)
//               slave  : memory-side responder (drives w_done/r_data/r_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_responder_if;
  import config_pkg::*;

  ddr_address_t address;
  logic         w_en;
  ddr_data_t    w_data;
  logic         w_done;
  logic         r_en;
  ddr_data_t    r_data;
  logic         r_valid;

  modport master (
    output address, w_en, w_data, r_en,
    input  w_done, r_data, r_valid
  );

  modport slave (
    input  address, w_en, w_data, r_en,
    output w_done, r_data, r_valid
  );

endinterface : ddr_responder_if
`default_nettype wire

// File: rtl/ddr_backing_ram.sv
`default_nettype none
// ============================================================================
// Module      : ddr_backing_ram
// Description : Single-port (1RW) synchronous-read RAM of DEPTH ddr_data_t
//               words. Read data appears the cycle after an enabled read and
//               holds until the next enabled read.
// Ports       : clk_i, en_i, we_i, addr_i, w_data_i -> r_data_o
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_backing_ram
  import config_pkg::*;
#(
  parameter int DEPTH = DdrDepth
) (
  input  wire logic                     clk_i,
  input  wire logic                     en_i,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] addr_i,
  input  wire ddr_data_t                w_data_i,
  output ddr_data_t                     r_data_o
);

  ddr_data_t r_mem [DEPTH];
  ddr_data_t r_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) r_mem[addr_i] <= w_data_i;
      else      r_q           <= r_mem[addr_i];
    end
  end

  assign r_data_o = r_q;

endmodule : ddr_backing_ram
`default_nettype wire

// File: rtl/ddr_responder.sv
`default_nettype none
// ============================================================================
// Module      : ddr_responder
// Description : Memory-side end of the DDR request interface. Serves
//               requester reads/writes from an on-chip RAM with programmable
//               latency and offers a host preload/readback port while idle.
// Ports       : clk_i, rst_i           - clock, sync active-high reset
//               ddr (slave modport)    - requester address/en/data, pulses
//               host_*                 - host single-cycle access port
//               busy_o, err_o          - status (err_o sticky until reset)
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_responder
  import config_pkg::*;
#(
  parameter int DEPTH         = DdrDepth,
  parameter int READ_LATENCY  = DdrReadLatency,
  parameter int WRITE_LATENCY = DdrWriteLatency
) (
  input  wire logic                     clk_i,
  input  wire logic                     rst_i,
  ddr_responder_if.slave                ddr,
  input  wire logic                     host_en_i,
  input  wire logic                     host_we_i,
  input  wire logic [$clog2(DEPTH)-1:0] host_addr_i,
  input  wire ddr_data_t                host_w_data_i,
  output ddr_data_t                     host_r_data_o,
  output logic                          host_ready_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ADDR_W  = $bits(ddr_address_t);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  ddr_resp_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_r_valid;
  logic             r_w_done;
  logic             r_oor;      // accepted read was out of range -> data 0
  logic             r_err;
  logic             r_host_rd;  // host read issued last cycle

  logic             w_idle;
  logic             w_req;
  logic             w_host;
  logic             w_oor;
  logic             w_ram_en;
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_addr;
  ddr_data_t        w_ram_wdata;
  ddr_data_t        w_ram_q;

  assign w_idle = (r_state == ST_IDLE);
  assign w_req  = w_idle && (ddr.w_en || ddr.r_en);
  assign w_host = w_idle && !(ddr.w_en || ddr.r_en) && host_en_i;
  assign w_oor  = |ddr.address[ADDR_W-1:AW];

  // Requester has priority for the single RAM port. Out-of-range requests
  // never touch the RAM.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = host_addr_i;
    w_ram_wdata = host_w_data_i;
    if (w_req) begin
      w_ram_en    = !w_oor;
      w_ram_we    = ddr.w_en;
      w_ram_addr  = ddr.address[AW-1:0];
      w_ram_wdata = ddr.w_data;
    end else if (w_host) begin
      w_ram_en    = 1'b1;
      w_ram_we    = host_we_i;
    end
  end

  ddr_backing_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i    (clk_i),
    .en_i     (w_ram_en),
    .we_i     (w_ram_we),
    .addr_i   (w_ram_addr),
    .w_data_i (w_ram_wdata),
    .r_data_o (w_ram_q)
  );

  // Pulses are registered one cycle early so that they coincide with the
  // wait-state cycle whose counter reads zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_r_valid <= 1'b0;
      r_w_done  <= 1'b0;
      r_oor     <= 1'b0;
      r_err     <= 1'b0;
      r_host_rd <= 1'b0;
    end else begin
      r_r_valid <= 1'b0;
      r_w_done  <= 1'b0;
      r_host_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ddr.w_en) begin
            r_cnt    <= WR_LOAD;
            r_state  <= ST_WRITE_WAIT;
            r_w_done <= (WRITE_LATENCY == 1);
            if (w_oor || ddr.r_en) r_err <= 1'b1;
          end else if (ddr.r_en) begin
            r_cnt     <= RD_LOAD;
            r_state   <= ST_READ_WAIT;
            r_oor     <= w_oor;
            r_r_valid <= (READ_LATENCY == 1);
            if (w_oor) r_err <= 1'b1;
          end else if (host_en_i && !host_we_i) begin
            r_host_rd <= 1'b1;
          end
        end
        ST_READ_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt     <= r_cnt - CNT_W'(1);
            r_r_valid <= (r_cnt == CNT_W'(1));
          end
        end
        ST_WRITE_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt    <= r_cnt - CNT_W'(1);
            r_w_done <= (r_cnt == CNT_W'(1));
          end
        end
        default: r_state <= ST_IDLE;  // ST_DONE: one dead cycle
      endcase
    end
  end

  // RAM output holds between accesses, so gating it with the flags is safe.
  assign ddr.r_data    = (r_r_valid && !r_oor) ? w_ram_q : '0;
  assign ddr.r_valid   = r_r_valid;
  assign ddr.w_done    = r_w_done;
  assign host_r_data_o = r_host_rd ? w_ram_q : '0;
  assign host_ready_o  = w_idle;
  assign busy_o        = !w_idle;
  assign err_o         = r_err;

endmodule : ddr_responder
`default_nettype wire

// File: doc/ddr_responder.md
Name: ddr_responder

Overview:
- Memory-side end of the accelerator's DDR request interface.
- Accepts read/write requests from a compute-unit requester: address, r_en, w_en, w_data.
- Serves them from an on-chip backing RAM with programmable latency, returning r_data/r_valid and w_done.
- Also gives the host a single-cycle preload/readback port for loading ternary weights and vectors before a run. Used as the simulation DDR model and as the on-chip stand-in for small configurations.

Parameters:
- Depth, 4096, number of ddr_data_t words in the backing RAM (power of two).
- ReadLatency, 4, cycles from request acceptance to r_valid (>=1).
- WriteLatency, 2, cycles from request acceptance to w_done (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ddr_address_i  in  $bits(ddr_address_t)  word address of the request
- ddr_w_en_i  in  1  write request, held until w_done
- ddr_w_data_i  in  $bits(ddr_data_t)  write data, held with w_en
- ddr_w_done_o  out  1  one-cycle write-complete pulse
- ddr_r_en_i  in  1  read request, held until r_valid
- ddr_r_data_o  out  $bits(ddr_data_t)  read data, valid only with r_valid
- ddr_r_valid_o  out  1  one-cycle read-data pulse
- host_en_i  in  1  host access strobe
- host_we_i  in  1  1 = host write, 0 = host read
- host_addr_i  in  $clog2(Depth)  host word address
- host_w_data_i  in  $bits(ddr_data_t)  host write data
- host_r_data_o  out  $bits(ddr_data_t)  host read data, registered, 1 cycle after host_en_i
- host_ready_o  out  1  high only in IDLE; host access accepted only when high
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky protocol/range error flag

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, latency counter=0, and all outputs are 0 except host_ready_o=1. Reset mid-operation abandons the transaction with no completion pulse. A write already committed to RAM stays written. RAM contents are not cleared.
- States: IDLE, READ_WAIT, WRITE_WAIT, DONE.
- IDLE, requester arbitration (requester takes priority over host in the same cycle; the host access is then ignored and host_ready_o must be honoured by the host):
  - w_en=1: accept. Write RAM at the address this cycle, load counter=WriteLatency-1, go to WRITE_WAIT.
  - r_en=1 (w_en=0): accept. Issue RAM read, capture the data, load counter=ReadLatency-1, go to READ_WAIT.
  - w_en=1 and r_en=1 together: the write wins, err_o is set, and the read is not served.
- IDLE, host access (when no requester request is accepted): host writes commit in the same cycle; host reads return on host_r_data_o the next cycle.
- READ_WAIT / WRITE_WAIT: the counter decrements each cycle. When the counter is 0, assert r_valid (with r_data) or w_done for exactly that cycle and go to DONE.
  - With Latency=1 the pulse occurs in the cycle after acceptance.
  - In general, acceptance at cycle t gives the pulse at cycle t+Latency.
- DONE: lasts one cycle, with all request inputs ignored (the requester still holds en in the pulse cycle). Then return to IDLE. Back-to-back requests therefore sustain one transaction per Latency+2 cycles.
- Requester inputs (address, data, en) are sampled only at acceptance. Changes while waiting are ignored. If en drops early, the pulse still fires.
- Address range: ddr_address_i bits above $clog2(Depth) must be 0.
  - Out-of-range read: r_data=0, normal timing, err_o set.
  - Out-of-range write: dropped, w_done still pulses, err_o set.
- err_o clears only on reset.
- ddr_r_data_o is driven 0 whenever r_valid=0, so an OR-merge upstream is safe.

Decomposition:
- config_pkg already holds ddr_address_t and ddr_data_t.
- Add ddr_resp_state_t (the 4-state enum) and the DdrDepth/DdrReadLatency/DdrWriteLatency defaults to config_pkg.
- Sub-module ddr_backing_ram: a 1RW synchronous-read RAM, Depth x ddr_data_t, with the port mux (requester vs host) in ddr_responder.

Test Plan:
1. Reset, host-write addr 5 = 0xA5A5, then requester r_en to addr 5 -> r_valid pulses exactly 4 cycles after acceptance with r_data=0xA5A5; r_data=0 on every other cycle; busy_o high for 5 cycles.
2. Requester write addr 10 = 0x1234 held until done -> w_done one pulse 2 cycles after acceptance. A subsequent read of addr 10 returns 0x1234. The held en during the pulse/DONE cycle does not cause a second write.
3. r_en and w_en raised together at addr 3, w_data=0x77 -> only w_done pulses, no r_valid, err_o=1 and stays 1. A host read of addr 3 gives 0x77.
4. Read at addr Depth (out of range) -> r_valid with r_data=0 and err_o=1. Write at addr Depth+2 -> w_done pulses and RAM addr 2 is unchanged.
5. rst_i asserted 2 cycles into a READ_WAIT -> no r_valid ever appears; next cycle state IDLE, host_ready_o=1, err_o=0.
6. Back-to-back reads of addrs 0,1,2 with en held until each valid -> three r_valid pulses spaced ReadLatency+2=6 cycles apart, each with correct data. A host_en_i raised during the transactions is ignored while host_ready_o=0.
